// File: rtl/adc_pkg.sv
// Shared types and constants for the averaging ADC acquisition block.
package adc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DLY,
    REQ,
    WAIT,
    DONE
  } adc_state_e;

  localparam int ADC_DATA_W      = 12;
  localparam int ADC_REQ_LEN_MIN = 2;

  // One guard bit above the worst-case sum of 2^avg_log2 samples.
  function automatic int adc_acc_width(input int data_w, input int avg_log2);
    return data_w + avg_log2 + 1;
  endfunction

endpackage

// File: rtl/adc_avg_accum.sv
// Running accumulator with clear/add and scaled result register.
// ADC_AVG_ROUND_EN selects round-half-up instead of floor on the result.
module adc_avg_accum
  import adc_pkg::*;
#(
  parameter int DATA_W   = ADC_DATA_W,
  parameter int AVG_LOG2 = 3
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     clear,
  input  logic                     add,
  input  logic                     load,
  input  logic signed [DATA_W-1:0] sample,
  output logic signed [DATA_W-1:0] result
);

  localparam int ACC_W = adc_acc_width(DATA_W, AVG_LOG2);

`ifdef ADC_AVG_ROUND_EN
  localparam logic signed [ACC_W-1:0] OFFSET =
    (AVG_LOG2 == 0) ? ACC_W'(0) : ACC_W'(1) << ((AVG_LOG2 > 0) ? AVG_LOG2 - 1 : 0);
`else
  localparam logic signed [ACC_W-1:0] OFFSET = '0;
`endif

  logic signed [ACC_W-1:0] acc;

  // load reads the pre-clear sum, so DONE may load and clear in one cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc    <= '0;
      result <= '0;
    end else begin
      if (load) begin
        result <= DATA_W'((acc + OFFSET) >>> AVG_LOG2);
      end
      if (clear) begin
        acc <= '0;
      end else if (add) begin
        acc <= acc + ACC_W'(sample);
      end
    end
  end

endmodule

// File: rtl/adc_avg_acquire.sv
// Burst ADC acquisition: sync-triggered req/rdy handshake over 2^AVG_LOG2
// samples, mean output, continuous mode and rdy timeout. Option: ADC_AVG_ROUND_EN.
module adc_avg_acquire
  import adc_pkg::*;
#(
  parameter int DATA_W    = ADC_DATA_W,
  parameter int AVG_LOG2  = 3,
  parameter int REQ_DELAY = 11,
  parameter int REQ_LEN   = ADC_REQ_LEN_MIN,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              syncro_i,
  input  logic              cont_i,
  output logic              adc_data_req_o,
  input  logic              adc_data_rdy_i,
  input  logic [DATA_W-1:0] adc_data_i,
  output logic [DATA_W-1:0] data_o,
  output logic              data_rdy_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int CNT_MAX = (TIMEOUT > REQ_DELAY) ?
                           ((TIMEOUT > REQ_LEN) ? TIMEOUT : REQ_LEN) :
                           ((REQ_DELAY > REQ_LEN) ? REQ_DELAY : REQ_LEN);
  localparam int CNT_W = $clog2(CNT_MAX + 1);
  localparam logic [AVG_LOG2:0] LAST_SAMPLE = (AVG_LOG2 + 1)'((1 << AVG_LOG2) - 1);

  adc_state_e          state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [AVG_LOG2:0]   samp_cnt, samp_next;
  logic                acc_clr, acc_add, acc_load, err_next;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state          <= IDLE;
      cnt            <= '0;
      samp_cnt       <= '0;
      adc_data_req_o <= 1'b0;
      data_rdy_o     <= 1'b0;
      err_o          <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      samp_cnt       <= samp_next;
      adc_data_req_o <= (state_next == REQ);
      data_rdy_o     <= acc_load;
      err_o          <= err_next;
    end
  end

  // DLY spans REQ_DELAY+1 cycles so the request rises REQ_DELAY+1 after sync.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    samp_next  = samp_cnt;
    acc_clr    = 1'b0;
    acc_add    = 1'b0;
    acc_load   = 1'b0;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (syncro_i) begin
          state_next = DLY;
          cnt_next   = '0;
          samp_next  = '0;
          acc_clr    = 1'b1;
        end
      end
      DLY: begin
        if (cnt == CNT_W'(REQ_DELAY)) begin
          state_next = REQ;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      REQ: begin
        if (cnt == CNT_W'(REQ_LEN - 1)) begin
          state_next = WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      WAIT: begin
        if (adc_data_rdy_i) begin
          acc_add    = 1'b1;
          samp_next  = samp_cnt + 1'b1;
          cnt_next   = '0;
          state_next = (samp_cnt == LAST_SAMPLE) ? DONE : DLY;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          state_next = IDLE;
          cnt_next   = '0;
          acc_clr    = 1'b1;
          err_next   = 1'b1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        acc_load = 1'b1;
        if (cont_i) begin
          state_next = DLY;
          cnt_next   = '0;
          samp_next  = '0;
          acc_clr    = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o = (state != IDLE);

  adc_avg_accum #(
    .DATA_W   (DATA_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_accum (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear   (acc_clr),
    .add     (acc_add),
    .load    (acc_load),
    .sample  (adc_data_i),
    .result  (data_o)
  );

endmodule

// File: tb/tb_adc_avg_acquire.sv
// Scoreboard bench for adc_avg_acquire with a behavioural ADC responder.
module tb_adc_avg_acquire;

  localparam int DATA_W    = 12;
  localparam int AVG_LOG2  = 3;
  localparam int REQ_DELAY = 11;
  localparam int REQ_LEN   = 2;
  localparam int TIMEOUT   = 64;

  logic clk = 1'b0;
  logic reset_i, syncro_i, cont_i;
  logic adc_data_req_o, adc_data_rdy_i, data_rdy_o, busy_o, err_o;
  logic [DATA_W-1:0] adc_data_i, data_o;

  logic              rdy_resp = 1'b0;
  logic              rdy_force;
  logic [DATA_W-1:0] resp_data = '0;
  logic [DATA_W-1:0] force_data;
  assign adc_data_rdy_i = rdy_resp | rdy_force;
  assign adc_data_i     = rdy_force ? force_data : resp_data;

  int checks = 0, errors = 0;
  int adc_q[$];
  int exp_q[$];
  int smp[8];
  int cyc = 0, req_run = 0, req_pulses = 0, last_fall = 0;
  int rdy_run = 0, rdy_cnt = 0, err_run = 0, err_cnt = 0, err_cyc = 0;

  always #5 clk = ~clk;

  adc_avg_acquire #(
    .DATA_W    (DATA_W),
    .AVG_LOG2  (AVG_LOG2),
    .REQ_DELAY (REQ_DELAY),
    .REQ_LEN   (REQ_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .syncro_i       (syncro_i),
    .cont_i         (cont_i),
    .adc_data_req_o (adc_data_req_o),
    .adc_data_rdy_i (adc_data_rdy_i),
    .adc_data_i     (adc_data_i),
    .data_o         (data_o),
    .data_rdy_o     (data_rdy_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  task automatic check(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int mean8(input int sum);
`ifdef ADC_AVG_ROUND_EN
    return (sum + 4) >>> 3;
`else
    return sum >>> 3;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic sync_pulse();
    syncro_i = 1'b1;
    tick(1);
    syncro_i = 1'b0;
  endtask

  task automatic queue_burst();
    int sum;
    sum = 0;
    foreach (smp[i]) begin
      adc_q.push_back(smp[i]);
      sum += smp[i];
    end
    exp_q.push_back(mean8(sum));
  endtask

  task automatic wait_results(input string tag, input int n, input int budget);
    int start, i;
    start = rdy_cnt;
    i = 0;
    while ((rdy_cnt - start) < n && i < budget) begin
      tick(1);
      i++;
    end
    check(tag, rdy_cnt - start, n);
  endtask

  // ADC model: answers two cycles after each request falls while samples remain.
  initial begin
    logic prev_req;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_req && !adc_data_req_o && adc_q.size() > 0) begin
        @(negedge clk);
        resp_data = DATA_W'(adc_q.pop_front());
        rdy_resp  = 1'b1;
        @(negedge clk);
        rdy_resp  = 1'b0;
      end
      prev_req = adc_data_req_o;
    end
  end

  // Output monitor: pulse widths, result scoreboard, timing stamps.
  always @(negedge clk) begin
    cyc++;
    if (adc_data_req_o) begin
      req_run++;
    end else if (req_run > 0) begin
      check("req_len", req_run, REQ_LEN);
      req_pulses++;
      last_fall = cyc;
      req_run = 0;
    end
    if (data_rdy_o) begin
      if (rdy_run == 0) rdy_cnt++;
      rdy_run++;
      check("rdy_expected", (exp_q.size() > 0) ? 1 : 0, 1);
      if (exp_q.size() > 0) check("data", int'($signed(data_o)), exp_q.pop_front());
    end else if (rdy_run > 0) begin
      check("rdy_len", rdy_run, 1);
      rdy_run = 0;
    end
    if (err_o) begin
      if (err_run == 0) begin
        err_cnt++;
        err_cyc = cyc;
      end
      err_run++;
    end else if (err_run > 0) begin
      check("err_len", err_run, 1);
      err_run = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int p0, r0, e0, reqbits, i;
    reset_i = 1'b1; syncro_i = 1'b0; cont_i = 1'b0;
    rdy_force = 1'b0; force_data = '0;
    tick(3);
    check("rst_req", adc_data_req_o, 0);
    check("rst_data", int'(data_o), 0);
    check("rst_rdy", data_rdy_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    reset_i = 1'b0;
    tick(2);

    // Ramp 100..800 -> 450
    foreach (smp[k]) smp[k] = 100 * (k + 1);
    queue_burst();
    p0 = req_pulses;
    sync_pulse();
    check("t1_busy_during", busy_o, 1);
    wait_results("t1_done", 1, 400);
    check("t1_rdy_high", data_rdy_o, 1);
    check("t1_busy_drop", busy_o, 0);
    tick(1);
    check("t1_rdy_low", data_rdy_o, 0);
    check("t1_req_pulses", req_pulses - p0, 8);
    check("t1_data_hold", int'($signed(data_o)), 450);

    // ADC stops answering at sample 3 -> timeout
    e0 = err_cnt; r0 = rdy_cnt;
    adc_q.push_back(10);
    adc_q.push_back(20);
    sync_pulse();
    i = 0;
    while (err_cnt == e0 && i < 600) begin
      tick(1);
      i++;
    end
    check("t4_err_seen", err_cnt - e0, 1);
    check("t4_err_delay", err_cyc - last_fall, TIMEOUT);
    check("t4_busy", busy_o, 0);
    tick(5);
    check("t4_no_rdy", rdy_cnt - r0, 0);
    check("t4_data_kept", int'($signed(data_o)), 450);
    check("t4_adc_q", adc_q.size(), 0);

    // Negative rounding case and full-scale case
    foreach (smp[k]) smp[k] = (k == 7) ? 2 : -2;
    queue_burst();
    sync_pulse();
    wait_results("t2_neg", 1, 400);
    foreach (smp[k]) smp[k] = 2047;
    queue_burst();
    sync_pulse();
    wait_results("t2_full", 1, 400);

    // Request window, ignored second sync and ignored early rdy
    smp = '{-2048, 2047, -1, 0, 1, 1000, -1000, 5};
    queue_burst();
    p0 = req_pulses; r0 = rdy_cnt;
    syncro_i = 1'b1;
    tick(1);
    syncro_i = 1'b0;
    reqbits = 0;
    for (int j = 0; j < 16; j++) begin
      if (j > 0) tick(1);
      reqbits |= int'(adc_data_req_o) << j;
      if (j == 1) begin rdy_force = 1'b1; force_data = 12'h5A5; end
      if (j == 3) rdy_force = 1'b0;
      if (j == 4) syncro_i = 1'b1;
      if (j == 5) syncro_i = 1'b0;
    end
    check("t3_req_window", reqbits, 32'h3000);
    wait_results("t3_done", 1, 400);
    tick(60);
    check("t3_single_burst", rdy_cnt - r0, 1);
    check("t3_req_pulses", req_pulses - p0, 8);
    check("t3_idle", busy_o, 0);

    // Continuous mode: three bursts from one sync
    foreach (smp[k]) smp[k] = 300;
    repeat (3) queue_burst();
    r0 = rdy_cnt;
    cont_i = 1'b1;
    sync_pulse();
    wait_results("t5_first", 1, 400);
    wait_results("t5_second", 1, 400);
    cont_i = 1'b0;
    wait_results("t5_third", 1, 400);
    tick(200);
    check("t5_stopped", rdy_cnt - r0, 3);
    check("t5_idle", busy_o, 0);
    check("t5_adc_q", adc_q.size(), 0);

    // Reset during sample 5
    repeat (8) adc_q.push_back(555);
    sync_pulse();
    i = 0;
    while (adc_q.size() > 4 && i < 400) begin
      tick(1);
      i++;
    end
    check("t6_reached_s5", adc_q.size(), 4);
    tick(3);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    check("t6_req", adc_data_req_o, 0);
    check("t6_data", int'(data_o), 0);
    check("t6_rdy", data_rdy_o, 0);
    check("t6_busy", busy_o, 0);
    check("t6_err", err_o, 0);
    adc_q.delete();
    e0 = err_cnt; r0 = rdy_cnt;
    tick(40);
    check("t6_silent_rdy", rdy_cnt - r0, 0);
    check("t6_silent_err", err_cnt - e0, 0);
    foreach (smp[k]) smp[k] = -100;
    queue_burst();
    sync_pulse();
    wait_results("t6_after", 1, 400);
    tick(3);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
